// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters through an issue register and a response register.
// Latency: request accepted at edge N, response valid from edge N+1; one op per cycle sustained.
// Backpressure: a stalled response holds both stages, and no new grant is given while issue is full.
module alu_share_arbiter #(
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 4,
    parameter int FIXED_PRIO = 0
) (
    input  logic                   clock__i,
    input  logic                   reset_n__i,
    input  logic [1:0]             req_valid__i,
    output logic [1:0]             req_ready__o,
    input  logic [1:0][DATA_W-1:0] req_a__i,
    input  logic [1:0][DATA_W-1:0] req_b__i,
    input  logic [1:0][2:0]        req_ctrl__i,
    input  logic [1:0][TAG_W-1:0]  req_tag__i,
    output logic [DATA_W-1:0]      alu_a__o,
    output logic [DATA_W-1:0]      alu_b__o,
    output logic [2:0]             alu_ctrl__o,
    input  logic [DATA_W-1:0]      alu_result__i,
    input  logic                   alu_zero__i,
    output logic                   rsp_valid__o,
    input  logic                   rsp_ready__i,
    output logic                   rsp_id__o,
    output logic [TAG_W-1:0]       rsp_tag__o,
    output logic [DATA_W-1:0]      rsp_result__o,
    output logic                   rsp_zero__o,
    output logic                   rsp_err__o
);

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_ILL = 3'b101;

    typedef struct packed {
        logic              v;
        logic              id;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [2:0]        ctrl;
        logic [TAG_W-1:0]  tag;
    } iss_t;

    typedef struct packed {
        logic              v;
        logic              id;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              err;
    } rsp_t;

    iss_t iss;
    rsp_t rsp;
    logic rr_last;

    logic       adv_rsp;
    logic       adv_iss;
    logic [1:0] grant;
    logic       req_hs;
    logic       hs_id;
    logic       iss_err;

    assign adv_rsp = !rsp.v || rsp_ready__i;
    assign adv_iss = !iss.v || adv_rsp;

    // Ready is held low while reset is asserted, even before the first reset edge.
    always_comb begin
        grant = 2'b00;
        if (adv_iss && reset_n__i) begin
            case (req_valid__i)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ((FIXED_PRIO != 0) || rr_last) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready__o = grant;
    assign req_hs       = |(req_valid__i & grant);
    assign hs_id        = grant[1];
    assign iss_err      = (iss.ctrl == OP_ILL);

    assign alu_a__o    = iss.v ? iss.a    : '0;
    assign alu_b__o    = iss.v ? iss.b    : '0;
    assign alu_ctrl__o = iss.v ? iss.ctrl : OP_ADD;

    always_ff @(posedge clock__i) begin
        if (!reset_n__i) begin
            iss     <= '0;
            rsp     <= '0;
            rr_last <= 1'b1;
        end else begin
            if (adv_rsp) begin
                if (iss.v) begin
                    rsp.v      <= 1'b1;
                    rsp.id     <= iss.id;
                    rsp.tag    <= iss.tag;
                    rsp.result <= iss_err ? DATA_W'(1) : alu_result__i;
                    rsp.zero   <= iss_err ? 1'b0 : alu_zero__i;
                    rsp.err    <= iss_err;
                end else begin
                    rsp.v <= 1'b0;
                end
            end
            if (adv_iss) begin
                if (req_hs) begin
                    iss.v    <= 1'b1;
                    iss.id   <= hs_id;
                    iss.a    <= req_a__i[hs_id];
                    iss.b    <= req_b__i[hs_id];
                    iss.ctrl <= req_ctrl__i[hs_id];
                    iss.tag  <= req_tag__i[hs_id];
                    rr_last  <= hs_id;
                end else begin
                    iss.v <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid__o  = rsp.v;
    assign rsp_id__o     = rsp.id;
    assign rsp_tag__o    = rsp.tag;
    assign rsp_result__o = rsp.result;
    assign rsp_zero__o   = rsp.zero;
    assign rsp_err__o    = rsp.err;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: round-robin and fixed-priority instances share stimulus, each with its own ALU model.
module tb_alu_share_arbiter;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic [1:0][2:0]  req_ctrl;
    logic [1:0][3:0]  req_tag;
    logic             rsp_ready;

    logic [1:0]  rdy, fp_rdy;
    logic [31:0] alu_a, alu_b, fp_alu_a, fp_alu_b;
    logic [2:0]  alu_ctrl, fp_alu_ctrl;
    logic [31:0] alu_res, fp_alu_res;
    logic        alu_zero, fp_alu_zero;
    logic        rsp_v, rsp_id, rsp_zero, rsp_err;
    logic [3:0]  rsp_tag;
    logic [31:0] rsp_res;
    logic        fp_rsp_v, fp_rsp_id, fp_rsp_zero, fp_rsp_err;
    logic [3:0]  fp_rsp_tag;
    logic [31:0] fp_rsp_res;

    always #5 clk = ~clk;

    // External ALU; the illegal op returns junk so the forced error response is visible.
    function automatic logic [32:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        logic [31:0] r;
        case (c)
            3'b010:  r = a + b;
            3'b110:  r = a - b;
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b011:  r = a ^ b;
            3'b100:  r = ~(a | b);
            3'b111:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return {1'b1, 32'hDEAD_BEEF};
        endcase
        return {(r == 32'd0), r};
    endfunction

    assign {alu_zero, alu_res}       = alu(alu_a, alu_b, alu_ctrl);
    assign {fp_alu_zero, fp_alu_res} = alu(fp_alu_a, fp_alu_b, fp_alu_ctrl);

    alu_share_arbiter #(.DATA_W(32), .TAG_W(4), .FIXED_PRIO(0)) dut (
        .clock__i(clk), .reset_n__i(rst_n),
        .req_valid__i(req_valid), .req_ready__o(rdy),
        .req_a__i(req_a), .req_b__i(req_b), .req_ctrl__i(req_ctrl), .req_tag__i(req_tag),
        .alu_a__o(alu_a), .alu_b__o(alu_b), .alu_ctrl__o(alu_ctrl),
        .alu_result__i(alu_res), .alu_zero__i(alu_zero),
        .rsp_valid__o(rsp_v), .rsp_ready__i(rsp_ready), .rsp_id__o(rsp_id),
        .rsp_tag__o(rsp_tag), .rsp_result__o(rsp_res), .rsp_zero__o(rsp_zero), .rsp_err__o(rsp_err)
    );

    alu_share_arbiter #(.DATA_W(32), .TAG_W(4), .FIXED_PRIO(1)) dut_fp (
        .clock__i(clk), .reset_n__i(rst_n),
        .req_valid__i(req_valid), .req_ready__o(fp_rdy),
        .req_a__i(req_a), .req_b__i(req_b), .req_ctrl__i(req_ctrl), .req_tag__i(req_tag),
        .alu_a__o(fp_alu_a), .alu_b__o(fp_alu_b), .alu_ctrl__o(fp_alu_ctrl),
        .alu_result__i(fp_alu_res), .alu_zero__i(fp_alu_zero),
        .rsp_valid__o(fp_rsp_v), .rsp_ready__i(rsp_ready), .rsp_id__o(fp_rsp_id),
        .rsp_tag__o(fp_rsp_tag), .rsp_result__o(fp_rsp_res), .rsp_zero__o(fp_rsp_zero), .rsp_err__o(fp_rsp_err)
    );

    typedef struct {
        logic        port;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctrl;
        logic [3:0]  tag;
        logic [31:0] res;
        logic        zero;
        logic        err;
    } vec_t;

    vec_t vecs[11];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic p, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] c, input logic [3:0] t);
        req_a[p]    = a;
        req_b[p]    = b;
        req_ctrl[p] = c;
        req_tag[p]  = t;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        logic [1:0] exp_rdy;
        v = vecs[i];
        exp_rdy = (v.port) ? 2'b10 : 2'b01;
        req_valid = 2'b00;
        req_valid[v.port] = 1'b1;
        load(v.port, v.a, v.b, v.ctrl, v.tag);
        #1;
        chk($sformatf("v%0d ready", i), 64'(rdy), 64'(exp_rdy));
        tick();
        req_valid = 2'b00;
        #1;
        chk($sformatf("v%0d iss ctrl", i), 64'(alu_ctrl), 64'(v.ctrl));
        chk($sformatf("v%0d rsp not yet", i), 64'(rsp_v), 64'd0);
        tick();
        #1;
        chk($sformatf("v%0d rsp_valid", i), 64'(rsp_v), 64'd1);
        chk($sformatf("v%0d rsp_id", i), 64'(rsp_id), 64'(v.port));
        chk($sformatf("v%0d rsp_tag", i), 64'(rsp_tag), 64'(v.tag));
        chk($sformatf("v%0d result", i), 64'(rsp_res), 64'(v.res));
        chk($sformatf("v%0d zero", i), 64'(rsp_zero), 64'(v.zero));
        chk($sformatf("v%0d err", i), 64'(rsp_err), 64'(v.err));
        chk($sformatf("v%0d alu idle ctrl", i), 64'(alu_ctrl), 64'(3'b010));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got_res[$];
        logic [3:0]  got_tag[$];
        logic [31:0] exp_res[3];
        logic [3:0]  exp_tag[3];
        int  acc;
        int  idx;
        logic hs;

        //            port  a             b             ctrl    tag   result        zero  err
        vecs[0]  = '{1'b0, 32'd7,        32'd5,        3'b010, 4'd3, 32'd12,       1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'd9,        32'd9,        3'b110, 4'd5, 32'd0,        1'b1, 1'b0};
        vecs[2]  = '{1'b1, 32'hFFFFFFFF, 32'd1,        3'b111, 4'd6, 32'd1,        1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'hF0F01234, 32'h0FF0FF00, 3'b000, 4'd1, 32'h00F01200, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 32'h000000A0, 32'h0000000B, 3'b001, 4'd2, 32'h000000AB, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 32'h55555555, 32'h55555555, 3'b011, 4'd4, 32'd0,        1'b1, 1'b0};
        vecs[6]  = '{1'b1, 32'd0,        32'd0,        3'b100, 4'd7, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 32'd1,        32'hFFFFFFFF, 3'b111, 4'd8, 32'd0,        1'b1, 1'b0};
        vecs[8]  = '{1'b0, 32'd3,        32'd4,        3'b101, 4'd9, 32'd1,        1'b0, 1'b1};
        vecs[9]  = '{1'b1, 32'd3,        32'd5,        3'b110, 4'd10, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 32'd1,        32'd2,        3'b010, 4'd9, 32'd3,        1'b0, 1'b0};

        // Reset held 3 cycles with both ports requesting.
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        load(1'b0, 32'd11, 32'd22, 3'b010, 4'd1);
        load(1'b1, 32'd33, 32'd44, 3'b110, 4'd2);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("reset ready", 64'(rdy), 64'd0);
            chk("reset fp ready", 64'(fp_rdy), 64'd0);
            chk("reset rsp_valid", 64'(rsp_v), 64'd0);
            chk("reset alu_ctrl", 64'(alu_ctrl), 64'(3'b010));
            chk("reset alu_a/b", 64'({alu_a, alu_b}), 64'd0);
            chk("reset rsp payload", 64'({rsp_id, rsp_tag, rsp_res, rsp_zero, rsp_err}), 64'd0);
        end
        req_valid = 2'b00;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(i);

        // Both ports valid: RR alternates starting with port 0, fixed priority always port 0.
        load(1'b0, 32'd1, 32'd1, 3'b010, 4'd1);
        load(1'b1, 32'd2, 32'd2, 3'b010, 4'd2);
        for (int c = 0; c < 8; c++) begin
            req_valid = (c < 6) ? 2'b11 : 2'b00;
            #1;
            if (c < 6) begin
                chk($sformatf("rr grant c%0d", c), 64'(rdy), (c % 2 == 0) ? 64'd1 : 64'd2);
                chk($sformatf("fp grant c%0d", c), 64'(fp_rdy), 64'd1);
            end
            if (c >= 2) begin
                chk($sformatf("rr rsp_id c%0d", c), 64'(rsp_id), 64'((c - 2) % 2));
                chk($sformatf("rr result c%0d", c), 64'(rsp_res), (c % 2 == 0) ? 64'd2 : 64'd4);
            end
            tick();
        end

        // Response stall for 4 cycles with continuous port 0 traffic.
        exp_res = '{32'd11, 32'd22, 32'd33};
        exp_tag = '{4'hA, 4'hB, 4'hC};
        acc = 0;
        idx = 0;
        req_valid = 2'b01;
        load(1'b0, 32'd10, 32'd1, 3'b010, 4'hA);
        for (int cyc = 0; cyc < 14; cyc++) begin
            rsp_ready = (cyc >= 4);
            #1;
            if (rsp_v && rsp_ready) begin
                got_res.push_back(rsp_res);
                got_tag.push_back(rsp_tag);
            end
            hs = req_valid[0] && rdy[0];
            if (cyc < 4 && hs) acc++;
            if (cyc == 2 || cyc == 3) begin
                chk($sformatf("stall ready c%0d", cyc), 64'(rdy), 64'd0);
                chk($sformatf("stall rsp held c%0d", cyc), 64'({rsp_v, rsp_tag, rsp_res}), 64'({1'b1, 4'hA, 32'd11}));
                chk($sformatf("stall alu_a c%0d", cyc), 64'(alu_a), 64'd20);
            end
            tick();
            if (hs) begin
                idx++;
                if (idx == 1) load(1'b0, 32'd20, 32'd2, 3'b010, 4'hB);
                else if (idx == 2) load(1'b0, 32'd30, 32'd3, 3'b010, 4'hC);
                else req_valid = 2'b00;
            end
        end
        chk("stall accepts", 64'(acc), 64'd2);
        chk("resume count", 64'(got_res.size()), 64'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < got_res.size()) begin
                chk($sformatf("resume result %0d", k), 64'(got_res[k]), 64'(exp_res[k]));
                chk($sformatf("resume tag %0d", k), 64'(got_tag[k]), 64'(exp_tag[k]));
            end else begin
                chk($sformatf("resume missing %0d", k), 64'd0, 64'd1);
            end
        end

        // Reset asserted while both stages are full and stalled.
        rsp_ready = 1'b0;
        req_valid = 2'b10;
        load(1'b1, 32'd8, 32'd3, 3'b110, 4'd7);
        tick();
        load(1'b1, 32'd1, 32'd1, 3'b010, 4'd8);
        tick();
        req_valid = 2'b00;
        #1;
        chk("pre-reset stalled rsp", 64'({rsp_v, rsp_res}), 64'({1'b1, 32'd5}));
        rst_n = 1'b0;
        #1;
        chk("mid-reset ready", 64'(rdy), 64'd0);
        tick();
        chk("post-reset rsp_valid", 64'(rsp_v), 64'd0);
        chk("post-reset alu_ctrl", 64'(alu_ctrl), 64'(3'b010));
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("no stale rsp c%0d", c), 64'(rsp_v), 64'd0);
        end
        req_valid = 2'b11;
        #1;
        chk("post-reset rr first", 64'(rdy), 64'd1);
        chk("post-reset fp first", 64'(fp_rdy), 64'd1);
        req_valid = 2'b00;
        tick();
        run_vec(10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
